seq_detector_param: RTL and testbench

- Parametrised serial pattern detector, the successor to the fixed "101" FSM detectors.
- Pattern value and length are runtime-programmable. Overlapping and non-overlapping match modes are selectable.
- A data_valid qualifier, a saturating match counter, and a choice of combinational or registered match output are provided.
- Sits on any 1-bit serial stream (UART/line decoders, framing sync) and flags each completed pattern occurrence.

---
 rtl/seq_detector_param_if.sv | 27 ++
 rtl/seq_detector_param.sv | 86 ++++++++
 tb/tb_seq_detector_param.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/seq_detector_param_if.sv
// rtl/seq_detector_param_if.sv - control, serial data and match signals of the pattern detector
interface seq_detector_param_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  localparam int LW = $clog2(PAT_W + 1);

  logic             pat_load;
  logic [PAT_W-1:0] pat_value;
  logic [LW-1:0]    pat_len;
  logic             overlap_en;
  logic             data_valid;
  logic             data_in;
  logic             cnt_clr;
  logic             match;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output pat_load, pat_value, pat_len, overlap_en, data_valid, data_in, cnt_clr,
    input  match, match_cnt
  );

  modport slave (
    input  pat_load, pat_value, pat_len, overlap_en, data_valid, data_in, cnt_clr,
    output match, match_cnt
  );
endinterface

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - runtime-programmable serial pattern detector with saturating match counter
module seq_detector_param #(
  parameter int               PAT_W   = 4,
  parameter int               CNT_W   = 8,
  parameter int               REG_OUT = 0,
  parameter logic [PAT_W-1:0] PAT_RST = 'b0101,
  parameter int               LEN_RST = 3
) (
  input logic                 clk,
  input logic                 rst,
  seq_detector_param_if.slave bus
);
  localparam int               LW       = $clog2(PAT_W + 1);
  localparam logic [LW-1:0]    FILL_MAX = LW'(PAT_W - 1);
  localparam logic [LW-1:0]    LEN_MAX  = LW'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [PAT_W:0]   ONE      = 1;

  logic [PAT_W-1:0] pat;
  logic [LW-1:0]    len;
  logic [PAT_W-2:0] hist;
  logic [LW-1:0]    fill;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             hit;
  logic [PAT_W-1:0] win;
  logic [PAT_W:0]   mask_full;
  logic [PAT_W-1:0] mask;
  logic [LW-1:0]    load_len;

  // The newest bit joins the history as the LSB; only the low len bits are compared.
  always_comb begin
    accept    = bus.data_valid & ~bus.pat_load;
    win       = {hist, bus.data_in};
    mask_full = (ONE << len) - ONE;
    mask      = mask_full[PAT_W-1:0];
    hit       = accept && (fill >= (len - LW'(1))) && (((win ^ pat) & mask) == '0);
    load_len  = ((bus.pat_len == '0) || (bus.pat_len > LEN_MAX)) ? LEN_MAX : bus.pat_len;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat  <= PAT_RST;
      len  <= LW'(LEN_RST);
      hist <= '0;
      fill <= '0;
      cnt  <= '0;
    end else begin
      if (bus.pat_load) begin
        pat  <= bus.pat_value;
        len  <= load_len;
        fill <= '0;
      end else if (accept) begin
        hist <= win[PAT_W-2:0];
        // Non-overlapping mode forgets the bits consumed by this match.
        if (hit && !bus.overlap_en)
          fill <= '0;
        else if (fill != FILL_MAX)
          fill <= fill + LW'(1);
      end

      if (bus.cnt_clr)
        cnt <= hit ? CNT_W'(1) : '0;
      else if (hit && (cnt != CNT_MAX))
        cnt <= cnt + CNT_W'(1);
    end
  end

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic match_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          match_q <= 1'b0;
        else
          match_q <= hit;
      end
      assign bus.match = match_q;
    end else begin : g_comb_out
      assign bus.match = hit;
    end
  endgenerate

  assign bus.match_cnt = cnt;
endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - directed bench: combinational-output DUT alongside registered-output 2-bit-counter DUT
module tb_seq_detector_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic prev  = 1'b0;

  seq_detector_param_if #(.PAT_W(4), .CNT_W(8)) if0 ();
  seq_detector_param_if #(.PAT_W(4), .CNT_W(2)) if1 ();

  seq_detector_param #(.PAT_W(4), .CNT_W(8), .REG_OUT(0)) u0 (
    .clk (clk),
    .rst (rst),
    .bus (if0.slave)
  );

  seq_detector_param #(.PAT_W(4), .CNT_W(2), .REG_OUT(1)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic [3:0] pv, input logic [2:0] pl,
                       input logic v, input logic d, input logic clr);
    if0.pat_load = ld;  if1.pat_load = ld;
    if0.pat_value = pv; if1.pat_value = pv;
    if0.pat_len = pl;   if1.pat_len = pl;
    if0.data_valid = v; if1.data_valid = v;
    if0.data_in = d;    if1.data_in = d;
    if0.cnt_clr = clr;  if1.cnt_clr = clr;
  endtask

  task automatic set_ov(input logic ov);
    if0.overlap_en = ov;
    if1.overlap_en = ov;
  endtask

  // exp is the hit expected from this cycle's bit; the registered DUT shows last cycle's hit.
  task automatic step(input logic v, input logic d, input logic clr, input logic exp);
    @(negedge clk);
    drive(1'b0, 4'h0, 3'd0, v, d, clr);
    #1;
    check("match_comb", 32'(if0.match), 32'(exp));
    check("match_reg", 32'(if1.match), 32'(prev));
    prev = exp;
  endtask

  task automatic load(input logic [3:0] pv, input logic [2:0] pl, input logic d);
    @(negedge clk);
    drive(1'b1, pv, pl, 1'b1, d, 1'b0);
    #1;
    check("match_comb_load", 32'(if0.match), 32'd0);
    check("match_reg_load", 32'(if1.match), 32'(prev));
    prev = 1'b0;
  endtask

  task automatic cnt_chk(input int e0, input int e1);
    check("cnt8", 32'(if0.match_cnt), 32'(e0));
    check("cnt2", 32'(if1.match_cnt), 32'(e1));
  endtask

  task automatic do_rst();
    @(negedge clk);
    drive(1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_match_comb", 32'(if0.match), 32'd0);
    check("rst_match_reg", 32'(if1.match), 32'd0);
    cnt_chk(0, 0);
    @(negedge clk);
    rst  = 1'b0;
    prev = 1'b0;
  endtask

  initial begin
    drive(1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    set_ov(1'b1);
    #1;
    check("init_match_comb", 32'(if0.match), 32'd0);
    check("init_match_reg", 32'(if1.match), 32'd0);
    cnt_chk(0, 0);
    @(negedge clk);
    rst = 1'b0;

    // default 101, overlapping
    step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 1); step(1, 0, 0, 0); step(1, 1, 0, 1);
    step(0, 0, 0, 0);
    cnt_chk(2, 2);

    // default 101, non-overlapping
    do_rst();
    set_ov(1'b0);
    step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 1); step(1, 0, 0, 0); step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    cnt_chk(1, 1);

    // load 1101 after a 1,0 prefix; the 1 during load would complete 101 if it were accepted
    do_rst();
    set_ov(1'b1);
    step(1, 1, 0, 0); step(1, 0, 0, 0);
    load(4'b1101, 3'd4, 1'b1);
    step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 1);
    step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 1);
    step(0, 0, 0, 0);
    cnt_chk(2, 2);

    // pat_len = 0 clamps to 4
    do_rst();
    load(4'b1101, 3'd0, 1'b0);
    step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 1);
    step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 1);
    step(0, 0, 0, 0);
    cnt_chk(2, 2);

    // valid gaps between bits of 101
    do_rst();
    step(1, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    step(1, 1, 0, 1);
    step(0, 0, 0, 0);
    cnt_chk(1, 1);

    // counter saturation (2-bit DUT) and clears
    do_rst();
    step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 1); step(1, 0, 0, 0);
    cnt_chk(1, 1);
    step(1, 1, 0, 1); step(1, 0, 0, 0);
    cnt_chk(2, 2);
    step(1, 1, 0, 1); step(1, 0, 0, 0);
    cnt_chk(3, 3);
    step(1, 1, 0, 1); step(1, 0, 0, 0);
    cnt_chk(4, 3);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    cnt_chk(0, 0);
    step(1, 1, 1, 1);
    step(0, 0, 0, 0);
    cnt_chk(1, 1);

    // reset mid-stream discards partial history
    do_rst();
    step(1, 1, 0, 0); step(1, 0, 0, 0);
    do_rst();
    step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 1);
    step(0, 0, 0, 0);
    cnt_chk(1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
